// File: rtl/instruction_memory_loader_if.sv
// Download-port bundle between the debug unit (master) and the instruction memory loader (slave).
interface instruction_memory_loader_if #(
  parameter int NBITS = 8
) ();
  logic             i_start;
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic [NBITS-1:0] o_mem_addr;
  logic [7:0]       o_mem_data;
  logic             o_mem_wr_en;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [NBITS-1:0] o_inst_count;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_mem_addr, o_mem_data, o_mem_wr_en, o_busy, o_done, o_error, o_inst_count
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_mem_addr, o_mem_data, o_mem_wr_en, o_busy, o_done, o_error, o_inst_count
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Streams UART bytes into consecutive instruction-memory cells from 0 and stops on a
// completed HALT word, or flags overflow when the last cell is filled without one.
module instruction_memory_loader #(
  parameter int          NBITS     = 8,
  parameter int          CELLS     = 256,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  instruction_memory_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_e;

  localparam logic [NBITS-1:0] LAST = NBITS'(CELLS - 1);

  state_e           state_q;
  logic [NBITS-1:0] addr_q, mem_addr_q, cnt_q;
  logic [1:0]       bcnt_q;
  logic [31:0]      word_q;
  logic [7:0]       data_q;
  logic             wr_q;
  logic [31:0]      word_d;

  // First byte of a word ends up in the MSB, matching big-endian fetch.
  assign word_d = {word_q[23:0], bus.i_rx_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          bcnt_q <= '0;
          word_q <= '0;
          cnt_q  <= '0;
          if (bus.i_start) state_q <= LOAD;
        end
        LOAD: begin
          if (bus.i_start) begin
            addr_q <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            cnt_q  <= '0;
          end else if (bus.i_rx_valid) begin
            mem_addr_q <= addr_q;
            data_q     <= bus.i_rx_data;
            wr_q       <= 1'b1;
            word_q     <= word_d;
            bcnt_q     <= bcnt_q + 2'd1;
            // Saturate rather than wrap; the last cell always closes a word and ends the load.
            if (addr_q != LAST) addr_q <= addr_q + 1'b1;
            if (bcnt_q == 2'd3) begin
              cnt_q <= cnt_q + 1'b1;
              if (word_d == HALT_INST)  state_q <= DONE;
              else if (addr_q == LAST)  state_q <= ERROR;
            end
          end
        end
        default: begin
          if (bus.i_start) begin
            state_q <= LOAD;
            addr_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_data   = data_q;
  assign bus.o_mem_wr_en  = wr_q;
  assign bus.o_inst_count = cnt_q;
  assign bus.o_busy       = (state_q == LOAD);
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_error      = (state_q == ERROR);
endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

- Sequences the byte-wide write port of the instruction memory (NBITS address, 8-bit cells, 32-bit big-endian fetch) during program download.
- Accepts a byte stream from the debug UART receiver and writes the bytes to consecutive addresses starting at 0.
- Reassembles each group of 4 bytes into an instruction and stops when the HALT instruction completes.
- Reports completion or overflow to the debug unit, which holds the CPU stalled while this block reports busy.

## Interface
- NBITS, 8, memory address width.
- CELLS, 256, number of byte cells; multiple of 4, at most 2**NBITS.
- HALT_INST, 32'hFFFFFFFF, instruction word that terminates a load.

- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle load command.
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data valid.
- o_mem_addr  output  NBITS  byte address to instruction memory.
- o_mem_data  output  8  byte to write.
- o_mem_wr_en  output  1  one-cycle write pulse; memory read is inhibited while high.
- o_busy  output  1  high in LOAD.
- o_done  output  1  high in DONE.
- o_error  output  1  high in ERROR.
- o_inst_count  output  NBITS  complete instructions written, including HALT.

## Operation
- States: IDLE, LOAD, DONE, ERROR; encoded 2 bits.
- IDLE:
  - i_start → LOAD.
  - Clear byte address counter, byte-in-word counter (2 bits), word shift register and o_inst_count.
- LOAD, each i_rx_valid:
  - Register o_mem_addr = address counter, o_mem_data = i_rx_data, o_mem_wr_en = 1.
  - Increment address counter.
  - Shift the byte into the word register: word = {word[23:0], byte]}, so the first byte is the MSB, matching fetch order.
  - Increment byte-in-word counter.
- On the 4th byte of a word:
  - Increment o_inst_count.
  - If {word[23:0], byte} == HALT_INST → DONE.
  - Otherwise, if the byte was written at address CELLS-1 → ERROR.
  - Otherwise stay in LOAD.
- In LOAD, i_start restarts the load: counters clear, state stays LOAD, and a simultaneous i_rx_valid is dropped (no write).
- DONE and ERROR:
  - i_rx_valid is ignored; no write.
  - o_mem_addr, o_inst_count and o_mem_data hold.
  - i_start → LOAD with counters cleared.
- IDLE ignores i_rx_valid.
- Address counter is NBITS wide and never wraps: ERROR is taken before it would pass CELLS-1.

## Timing
- Reset values: state IDLE; all outputs 0.
- Reset mid-load: returns to IDLE immediately. Bytes already written stay in memory. o_inst_count reads 0.
- Write latency: 1 cycle. i_rx_valid sampled at edge N; o_mem_wr_en high for exactly cycle N→N+1 with the matching address and data.
- Back-to-back i_rx_valid on consecutive cycles is supported: one write per cycle.
- The DONE or ERROR transition takes effect on the same edge that registers the final write. o_done/o_error rise in the same cycle as the final o_mem_wr_en pulse. o_busy falls on that edge.
- i_start to o_busy high: 1 cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - Stimulus: release i_rst_n; send 3 bytes without i_start.
  - Response: no o_mem_wr_en; all outputs 0.
- Normal load:
  - Stimulus: i_start; bytes 20,01,00,05, FF,FF,FF,FF back-to-back.
  - Response: writes at addresses 0–7 in order. At address 7, o_done=1 in the same cycle as the write pulse. o_inst_count=2; o_busy=0.
- Gapped strobes:
  - Stimulus: same 8 bytes with 3 idle cycles between strobes.
  - Response: identical writes; each pulse is 1 cycle wide, 1 cycle after its strobe.
- Overflow:
  - Stimulus: CELLS=16; 16 bytes of 00.
  - Response: writes at 0–15; o_error=1 with the address-15 pulse; o_inst_count=4. A 17th byte produces no write.
- Restart and abort:
  - Stimulus 1: i_start after DONE, then FF×4. Response: writes at addresses 0–3; o_done; o_inst_count=1.
  - Stimulus 2: i_start coincident with i_rx_valid mid-load. Response: that byte is dropped; the next byte is written at address 0.
- Async reset mid-load:
  - Stimulus: assert i_rst_n low between clock edges after 5 bytes.
  - Response: outputs 0 immediately; state IDLE.
